ship_datapath: RTL and testbench
================================

SHIP_DATAPATH -- requirements
Module: ship_datapath

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter START_X, default 8'd76: ship x after reset or game start.
REQ-002 The block SHALL have parameter SHIP_Y, default 7'd112: fixed top row of the ship sprite.
REQ-003 The block SHALL have parameter MAX_X, default 8'd152: largest legal ship x, equal to 160 minus the 8-pixel sprite width.
REQ-004 The block SHALL have parameter STEP, default 8'd2: pixels moved per update.
REQ-005 The block SHALL have parameter INIT_HEALTH, default 8'd3: health after reset or game start.
Ports (name, direction, width, meaning):
REQ-006 The block SHALL have port clk, input, 1: 50 MHz board clock.
REQ-007 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 The block SHALL have inputs startGameEn, shipUpdateEn and writeEn, each 1 bit: level enables from the game controller FSM, each held for many cycles.
REQ-009 The block SHALL have inputs move_left, move_right and hit, each 1 bit: active-high player buttons and collision flag.
REQ-010 The block SHALL have outputs x (8 bits), y (7 bits) and colour (3 bits): registered VGA pixel address and colour.
REQ-011 The block SHALL have output plot, 1 bit: pixel write strobe, one pixel per cycle.
REQ-012 The block SHALL have output ship_health, 8 bits: current health, returned to the controller.
REQ-013 The block SHALL have output busy, 1 bit: high while a render is in progress.

Function
REQ-014 The block SHALL register each enable once per clock and act only on its rising edge (previous sample 0, current sample 1), never on the level.
REQ-015 On the rising edge of startGameEn the block SHALL load ship_x=START_X, ship_health=INIT_HEALTH and prev_x=START_X.
REQ-016 On the rising edge of shipUpdateEn with move_left=1 and move_right=0, ship_x SHALL become ship_x-STEP, saturating at 0.
REQ-017 On the rising edge of shipUpdateEn with move_right=1 and move_left=0, ship_x SHALL become ship_x+STEP, saturating at MAX_X; the sum SHALL be computed 9 bits wide so it cannot wrap.
REQ-018 If move_left and move_right are both 1, or both 0, on the shipUpdateEn rising edge, ship_x SHALL be unchanged.
REQ-019 On the rising edge of shipUpdateEn with hit=1, ship_health SHALL decrement by 1, saturating at 0; it SHALL never wrap to 255.
REQ-020 If startGameEn and shipUpdateEn rise in the same cycle, start SHALL win and the update SHALL be discarded.
REQ-021 The FSM SHALL have states IDLE, ERASE and DRAW.
REQ-022 IDLE->ERASE SHALL occur on a writeEn rising edge; at that edge the block SHALL latch snap_x=ship_x and snap_health=ship_health, and clear a 6-bit counter cnt.
REQ-023 In ERASE, each cycle SHALL output x=prev_x+cnt[2:0], y=SHIP_Y+cnt[5:3], colour=3'b000, plot=1; after cnt=63 the FSM SHALL go to DRAW and cnt SHALL wrap to 0.
REQ-024 In DRAW, each cycle SHALL output x=snap_x+cnt[2:0], y=SHIP_Y+cnt[5:3], plot=1, and colour=3'b100 if snap_health<=1, else 3'b111.
REQ-025 After DRAW cnt=63, the block SHALL set prev_x=snap_x and return to IDLE.
REQ-026 Outputs SHALL be registered so that, for a writeEn edge sampled at clock edge N, plot and busy are high on edges N+1 through N+128 inclusive (64 erase pixels then 64 draw pixels, row-major), and low otherwise.
REQ-027 A writeEn rising edge while busy=1 SHALL be ignored, with no queueing.
REQ-028 Changes to ship_x or ship_health during a render SHALL not alter the pixels already in progress, because the render uses the snapshot.
REQ-029 A startGameEn edge during a render SHALL update the registers immediately; the render in progress SHALL still complete using prev_x and snap_x.
REQ-030 In IDLE, plot SHALL be 0 and x, y and colour SHALL hold their last values.

Reset
REQ-031 While reset=0, asynchronously: state=IDLE, ship_x=prev_x=snap_x=START_X, ship_health=snap_health=INIT_HEALTH, cnt=0, x=0, y=0, colour=0, plot=0, busy=0, all edge-detect registers=0.
REQ-032 Reset asserted mid-render SHALL abort the render immediately: plot=0 in the same cycle, with no further pixels.
REQ-033 After reset is released, the first enable edge SHALL be detected only if the enable was sampled 0 at least once after release.

Verification
REQ-034 The bench SHALL cover: reset release, then a writeEn pulse -> 64 pixels colour 0 at x 76..83, y 112..119, then 64 pixels colour 7 at the same addresses; plot high for exactly 128 cycles.
REQ-035 The bench SHALL cover: move_right held over 40 shipUpdateEn pulses -> ship_x=152 (saturated); a further pulse leaves ship_x=152.
REQ-036 The bench SHALL cover: hit=1 over 5 shipUpdateEn pulses -> ship_health 2,1,0,0,0; the next render draws colour 3'b100.
REQ-037 The bench SHALL cover: startGameEn and shipUpdateEn rising together with move_left=1 and hit=1 -> ship_x=76, ship_health=3.
REQ-038 The bench SHALL cover: a second writeEn edge at render cycle 50 -> ignored, total plot cycles=128; the next edge after busy falls starts a new render that erases at the previous snap_x.
REQ-039 The bench SHALL cover: reset=0 at render cycle 70 -> plot=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/ship_datapath.sv
// Ship state (position, health) plus an erase/draw renderer that streams an 8x8 sprite
// one pixel per cycle to a VGA frame-buffer write port.
module ship_datapath #(
  parameter logic [7:0] START_X     = 8'd76,
  parameter logic [6:0] SHIP_Y      = 7'd112,
  parameter logic [7:0] MAX_X       = 8'd152,
  parameter logic [7:0] STEP        = 8'd2,
  parameter logic [7:0] INIT_HEALTH = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startGameEn,
  input  logic       shipUpdateEn,
  input  logic       writeEn,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       hit,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [7:0] ship_health,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StErase, StDraw} state_e;

  state_e      state_q, state_d;
  logic [7:0]  ship_x_q, ship_x_d, prev_x_q, prev_x_d, snap_x_q, snap_x_d;
  logic [7:0]  health_q, health_d, snap_health_q, snap_health_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d, busy_q, busy_d;
  logic        start_q, upd_q, wr_q;
  // One bit per enable: set once the enable has been seen low after reset release.
  logic [2:0]  arm_q;
  logic        start_rise, upd_rise, wr_rise;
  logic [8:0]  sum9;

  assign start_rise = startGameEn  & ~start_q & arm_q[0];
  assign upd_rise   = shipUpdateEn & ~upd_q   & arm_q[1];
  assign wr_rise    = writeEn      & ~wr_q    & arm_q[2];
  assign sum9       = {1'b0, ship_x_q} + {1'b0, STEP};

  always_comb begin
    state_d       = state_q;
    ship_x_d      = ship_x_q;
    prev_x_d      = prev_x_q;
    snap_x_d      = snap_x_q;
    health_d      = health_q;
    snap_health_d = snap_health_q;
    cnt_d         = cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    colour_d      = colour_q;
    plot_d        = 1'b0;
    busy_d        = 1'b0;

    if (start_rise) begin
      ship_x_d = START_X;
      health_d = INIT_HEALTH;
    end else if (upd_rise) begin
      if (move_left && !move_right) begin
        ship_x_d = (ship_x_q < STEP) ? 8'd0 : ship_x_q - STEP;
      end else if (move_right && !move_left) begin
        ship_x_d = (sum9 > {1'b0, MAX_X}) ? MAX_X : sum9[7:0];
      end
      if (hit && health_q != 8'd0) health_d = health_q - 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (wr_rise) begin
          state_d       = StErase;
          snap_x_d      = ship_x_q;
          snap_health_d = health_q;
          cnt_d         = 6'd0;
        end
      end
      StErase: begin
        cnt_d    = cnt_q + 6'd1;
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        x_d      = prev_x_q + {5'd0, cnt_q[2:0]};
        y_d      = SHIP_Y + {4'd0, cnt_q[5:3]};
        colour_d = 3'b000;
        if (cnt_q == 6'd63) state_d = StDraw;
      end
      StDraw: begin
        cnt_d    = cnt_q + 6'd1;
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        x_d      = snap_x_q + {5'd0, cnt_q[2:0]};
        y_d      = SHIP_Y + {4'd0, cnt_q[5:3]};
        colour_d = (snap_health_q <= 8'd1) ? 3'b100 : 3'b111;
        if (cnt_q == 6'd63) begin
          state_d  = StIdle;
          prev_x_d = snap_x_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new game overrides the end-of-render prev_x update.
    if (start_rise) prev_x_d = START_X;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      ship_x_q      <= START_X;
      prev_x_q      <= START_X;
      snap_x_q      <= START_X;
      health_q      <= INIT_HEALTH;
      snap_health_q <= INIT_HEALTH;
      cnt_q         <= 6'd0;
      x_q           <= 8'd0;
      y_q           <= 7'd0;
      colour_q      <= 3'd0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
      upd_q         <= 1'b0;
      wr_q          <= 1'b0;
      arm_q         <= 3'b000;
    end else begin
      state_q       <= state_d;
      ship_x_q      <= ship_x_d;
      prev_x_q      <= prev_x_d;
      snap_x_q      <= snap_x_d;
      health_q      <= health_d;
      snap_health_q <= snap_health_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      busy_q        <= busy_d;
      start_q       <= startGameEn;
      upd_q         <= shipUpdateEn;
      wr_q          <= writeEn;
      arm_q         <= arm_q | ~{writeEn, shipUpdateEn, startGameEn};
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign busy        = busy_q;
  assign ship_health = health_q;

endmodule

// File: tb/tb_ship_datapath.sv
// Self-checking bench for ship_datapath: table-driven update vectors, randomized updates
// against a small position/health model, and full pixel-stream checks of every render.
module tb_ship_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       startGameEn, shipUpdateEn, writeEn;
  logic       move_left, move_right, hit;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [7:0] ship_health;
  logic       busy;

  always #5 clk = ~clk;

  ship_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .startGameEn (startGameEn),
    .shipUpdateEn(shipUpdateEn),
    .writeEn     (writeEn),
    .move_left   (move_left),
    .move_right  (move_right),
    .hit         (hit),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .ship_health (ship_health),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the game state: sprite position, health, and where the last sprite was drawn.
  int m_x, m_h, m_prev;

  typedef struct {
    bit l;
    bit r;
    bit h;
    int exp_x;
    int exp_h;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_start();
    m_x    = 76;
    m_h    = 3;
    m_prev = 76;
  endtask

  task automatic model_update(input bit l, input bit r, input bit h);
    if (l && !r) m_x = (m_x >= 2) ? m_x - 2 : 0;
    else if (r && !l) m_x = (m_x + 2 > 152) ? 152 : m_x + 2;
    if (h && m_h > 0) m_h = m_h - 1;
  endtask

  task automatic pulse_update(input bit l, input bit r, input bit h);
    @(negedge clk);
    move_left    = l;
    move_right   = r;
    hit          = h;
    shipUpdateEn = 1'b1;
    @(negedge clk);
    shipUpdateEn = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    startGameEn = 1'b1;
    @(negedge clk);
    startGameEn = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: plain render; 1: extra writeEn edge at pixel 50; 2: reset at pixel 70;
  // 3: left-move update pulse at pixel 30 (must not disturb the pixels in flight).
  task automatic render(input int mode);
    int ex, dx, col, plots, base, i;
    bit aborted;
    logic [7:0] wx;
    logic [6:0] wy;
    logic [2:0] wc;
    ex      = m_prev;
    dx      = m_x;
    col     = (m_h <= 1) ? 4 : 7;
    plots   = 0;
    aborted = 1'b0;
    wx      = 8'd0;
    wy      = 7'd0;
    wc      = 3'd0;
    @(negedge clk);
    writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      base = (k < 64) ? ex : dx;
      i    = k % 64;
      wx   = 8'(base + i % 8);
      wy   = 7'(112 + i / 8);
      wc   = (k < 64) ? 3'd0 : 3'(col);
      check($sformatf("pixel%0d_mode%0d", k, mode), {12'd0, plot, busy, x, y, colour},
            {12'd0, 1'b1, 1'b1, wx, wy, wc});
      if (plot) plots++;
      if (mode == 1 && k == 50) writeEn = 1'b1;
      if (mode == 1 && k == 52) writeEn = 1'b0;
      if (mode == 3 && k == 30) begin
        move_left    = 1'b1;
        move_right   = 1'b0;
        hit          = 1'b0;
        shipUpdateEn = 1'b1;
      end
      if (mode == 3 && k == 32) begin
        shipUpdateEn = 1'b0;
        model_update(1'b1, 1'b0, 1'b0);
      end
      if (mode == 2 && k == 70) begin
        reset = 1'b0;
        #1;
        check("abort_outputs", {12'd0, plot, busy, x, y, colour}, 32'd0);
        check("abort_health", {24'd0, ship_health}, 32'd3);
        @(negedge clk);
        check("abort_plot_held", {31'd0, plot}, 32'd0);
        reset = 1'b1;
        model_start();
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      m_prev = dx;
      repeat (20) begin
        @(negedge clk);
        if (plot) plots++;
      end
      check($sformatf("plot_cycles_mode%0d", mode), plots, 128);
      check($sformatf("idle_hold_mode%0d", mode), {12'd0, plot, busy, x, y, colour},
            {12'd0, 1'b0, 1'b0, wx, wy, wc});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit l, r, h;
    int hit_exp[5];

    tbl[0] = '{l: 1, r: 0, h: 0, exp_x: 74, exp_h: 3};
    tbl[1] = '{l: 1, r: 1, h: 0, exp_x: 74, exp_h: 3};
    tbl[2] = '{l: 0, r: 0, h: 1, exp_x: 74, exp_h: 2};
    tbl[3] = '{l: 0, r: 1, h: 0, exp_x: 76, exp_h: 2};
    tbl[4] = '{l: 0, r: 1, h: 1, exp_x: 78, exp_h: 1};
    tbl[5] = '{l: 1, r: 0, h: 0, exp_x: 76, exp_h: 1};
    hit_exp = '{2, 1, 0, 0, 0};

    // Reset with an update enable already held high: it must not count as an edge.
    reset        = 1'b0;
    startGameEn  = 1'b0;
    writeEn      = 1'b0;
    shipUpdateEn = 1'b1;
    move_left    = 1'b0;
    move_right   = 1'b1;
    hit          = 1'b1;
    model_start();
    repeat (3) @(negedge clk);
    check("reset_outputs", {12'd0, plot, busy, x, y, colour}, 32'd0);
    check("reset_health", {24'd0, ship_health}, 32'd3);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("held_enable_no_edge_health", {24'd0, ship_health}, 32'd3);
    shipUpdateEn = 1'b0;
    move_right   = 1'b0;
    hit          = 1'b0;
    @(negedge clk);
    render(0);

    for (int t = 0; t < 6; t++) begin
      pulse_update(tbl[t].l, tbl[t].r, tbl[t].h);
      check($sformatf("table%0d_health", t), {24'd0, ship_health}, tbl[t].exp_h);
      m_x = tbl[t].exp_x;
      m_h = tbl[t].exp_h;
      render(0);
    end

    pulse_start();
    model_start();
    check("start_health", {24'd0, ship_health}, 32'd3);
    render(0);

    for (int t = 0; t < 40; t++) begin
      pulse_update(1'b0, 1'b1, 1'b0);
      model_update(1'b0, 1'b1, 1'b0);
    end
    render(0);
    pulse_update(1'b0, 1'b1, 1'b0);
    model_update(1'b0, 1'b1, 1'b0);
    render(0);

    pulse_start();
    model_start();
    for (int t = 0; t < 5; t++) begin
      pulse_update(1'b0, 1'b0, 1'b1);
      model_update(1'b0, 1'b0, 1'b1);
      check($sformatf("hit%0d_health", t), {24'd0, ship_health}, hit_exp[t]);
    end
    render(0);

    // Start and update rise together: start wins.
    @(negedge clk);
    move_left    = 1'b1;
    move_right   = 1'b0;
    hit          = 1'b1;
    startGameEn  = 1'b1;
    shipUpdateEn = 1'b1;
    @(negedge clk);
    startGameEn  = 1'b0;
    shipUpdateEn = 1'b0;
    @(negedge clk);
    model_start();
    check("start_wins_health", {24'd0, ship_health}, 32'd3);
    render(0);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_start();
        model_start();
      end else begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        h = ($urandom_range(0, 3) == 0);
        pulse_update(l, r, h);
        model_update(l, r, h);
      end
      check($sformatf("rand%0d_health", t), {24'd0, ship_health}, m_h);
      if (t % 6 == 5) render(0);
    end

    render(3);
    render(0);
    render(1);
    render(0);
    render(2);
    repeat (2) @(negedge clk);
    render(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
